uart_tx_sequencer: RTL and testbench

- Transmit-side controller for the full UART.
- Accepts a byte from the processor-side write strobe, builds an 11-bit-time frame (start, 7/8 data, optional parity, stop fill) and shifts it out LSB-first at the programmed baud rate.
- Maintains the TXRDY status flag with set/reset semantics and emits an end-of-frame pulse for the interrupt logic.
- Sits between the UART register/decode logic and the serial TX pin.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_timer.sv | 37 +++
 rtl/uart_tx_sequencer.sv | 157 +++++++++++++++
 tb/tb_uart_tx_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit and receive sequencers.
package uart_pkg;

    localparam int DIV_W_DEF  = 20;
    localparam int FRAME_BITS = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } uart_state_e;

    // Parity over 7 or 8 data bits; odd selects the inverted (odd) sense.
    function automatic logic calc_parity(input logic [7:0] data,
                                         input logic       eight,
                                         input logic       odd);
        return (^data[6:0]) ^ (eight & data[7]) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Bit-time counter: counts 0..limit while running, flags the last clock of a bit.
module uart_baud_timer #(
    parameter int DIV_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             run_i,
    input  logic [DIV_W-1:0] limit_i,
    output logic             done_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign done_o = run_i & (cnt_q == limit_i);

    // Next count: clear wins, otherwise wrap at the terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = (cnt_q == limit_i) ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: captures a byte, builds an 11-bit-time frame and
// shifts it out LSB-first. tx, tx_rdy and tx_done are all registered.
// Handshake: a write is taken only on a cycle where write=1 and tx_rdy=1;
// tx_rdy drops the next cycle and rises again with the tx_done pulse.
module uart_tx_sequencer #(
    parameter int DIV_W      = uart_pkg::DIV_W_DEF,
    parameter int FRAME_BITS = uart_pkg::FRAME_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] baud_k,
    input  logic             eight,
    input  logic             pen,
    input  logic             ohel,
    input  logic             write,
    input  logic [7:0]       data_in,
    output logic             tx,
    output logic             tx_rdy,
    output logic             tx_done
);

    import uart_pkg::*;

    uart_state_e            state_q, state_d;
    logic [7:0]             data_q, data_d;
    logic                   eight_q, eight_d;
    logic                   pen_q, pen_d;
    logic                   ohel_q, ohel_d;
    logic [DIV_W-1:0]       k_q, k_d;
    logic [FRAME_BITS-1:0]  shreg_q, shreg_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic                   tx_q, tx_d;
    logic                   rdy_q, rdy_d;
    logic                   done_q, done_d;

    logic                   accept;
    logic                   bit_tick;
    logic                   frame_end;
    logic                   par;
    logic [FRAME_BITS-1:0]  frame;
    logic [DIV_W-1:0]       k_eff;

    assign accept    = write & rdy_q & (state_q == IDLE);
    assign frame_end = (state_q == SHIFT) & bit_tick & (bit_cnt_q == 4'(FRAME_BITS - 1));
    assign k_eff     = (baud_k < DIV_W'(2)) ? DIV_W'(2) : baud_k;
    assign par       = calc_parity(data_q, eight_q, ohel_q);
    // Index 0 is the start bit; unused data/parity slots become stop fill.
    assign frame     = {1'b1,
                        (eight_q & pen_q) ? par : 1'b1,
                        eight_q ? data_q[7] : (pen_q ? par : 1'b1),
                        data_q[6:0],
                        1'b0};

    uart_baud_timer #(.DIV_W(DIV_W)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .clear_i (state_q != SHIFT),
        .run_i   (state_q == SHIFT),
        .limit_i (k_q - 1'b1),
        .done_o  (bit_tick)
    );

    // Next-state and datapath for the IDLE/LOAD/SHIFT sequencer.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        eight_d   = eight_q;
        pen_d     = pen_q;
        ohel_d    = ohel_q;
        k_d       = k_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    state_d = LOAD;
                    data_d  = data_in;
                    eight_d = eight;
                    pen_d   = pen;
                    ohel_d  = ohel;
                    k_d     = k_eff;
                end
            end
            LOAD: begin
                shreg_d   = frame;
                tx_d      = frame[0];
                bit_cnt_d = '0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                if (bit_tick) begin
                    shreg_d = {1'b1, shreg_q[FRAME_BITS-1:1]};
                    if (frame_end) begin
                        bit_cnt_d = '0;
                        tx_d      = 1'b1;
                        done_d    = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_d      = shreg_q[1];
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Ready flag: set at frame end (priority), cleared by an accepted write.
    always_comb begin
        rdy_d = rdy_q;
        if (frame_end) begin
            rdy_d = 1'b1;
        end else if (accept) begin
            rdy_d = 1'b0;
        end
    end

    // State and datapath registers; reset forces an idle line at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            eight_q   <= 1'b0;
            pen_q     <= 1'b0;
            ohel_q    <= 1'b0;
            k_q       <= '0;
            shreg_q   <= '1;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            rdy_q     <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            eight_q   <= eight_d;
            pen_q     <= pen_d;
            ohel_q    <= ohel_d;
            k_q       <= k_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rdy_q     <= rdy_d;
            done_q    <= done_d;
        end
    end

    assign tx      = tx_q;
    assign tx_rdy  = rdy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Bench for uart_tx_sequencer: a per-cycle reference model of the serial
// line and status flags, plus literal frames for the directed cases.
module tb_uart_tx_sequencer;

    localparam int DIV_W = 20;

    logic             clk;
    logic             rst;
    logic [DIV_W-1:0] baud_k;
    logic             eight;
    logic             pen;
    logic             ohel;
    logic             write;
    logic [7:0]       data_in;
    logic             tx;
    logic             tx_rdy;
    logic             tx_done;

    int total = 0;
    int bad   = 0;

    // Expected {tx, tx_rdy, tx_done} for upcoming cycles; empty means idle.
    logic [2:0] exp_q[$];
    logic [2:0] exp_now;

    uart_tx_sequencer #(.DIV_W(DIV_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .baud_k  (baud_k),
        .eight   (eight),
        .pen     (pen),
        .ohel    (ohel),
        .write   (write),
        .data_in (data_in),
        .tx      (tx),
        .tx_rdy  (tx_rdy),
        .tx_done (tx_done)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame bits in transmit order, derived from the framing rules.
    function automatic logic [10:0] model_frame(input logic [7:0] d, input logic e,
                                                input logic p, input logic o);
        logic [10:0] f;
        int n;
        int ones;
        f    = '1;
        f[0] = 1'b0;
        n    = e ? 8 : 7;
        ones = 0;
        for (int i = 0; i < n; i++) begin
            f[1 + i] = d[i];
            ones += int'(d[i]);
        end
        if (p) f[1 + n] = ((ones % 2) == 1) ^ o;
        return f;
    endfunction

    // Scoreboard: compare every cycle, then enqueue the frame for an accepted write.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_now = 3'b110;
        end else begin
            exp_now = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b110;
        end
        chk("line", {29'd0, tx, tx_rdy, tx_done}, {29'd0, exp_now});
        if (!rst && write && exp_now[1]) begin
            logic [10:0] f;
            int k;
            f = model_frame(data_in, eight, pen, ohel);
            k = (baud_k < 2) ? 2 : int'(baud_k);
            exp_q.push_back(3'b100);
            for (int b = 0; b < 11; b++)
                for (int c = 0; c < k; c++)
                    exp_q.push_back({f[b], 2'b00});
            exp_q.push_back(3'b111);
        end
    end

    // Driver: present one write for exactly one cycle; returns during LOAD.
    task automatic send(input logic [7:0] d, input logic e, input logic p,
                        input logic o, input int k);
        @(posedge clk); #1;
        data_in = d; eight = e; pen = p; ohel = o; baud_k = DIV_W'(k);
        write = 1'b1;
        @(posedge clk); #1;
        write = 1'b0;
    endtask

    // Literal check of a frame; called during the LOAD cycle, returns in the tx_done cycle.
    task automatic expect_frame(input string name, input logic [10:0] lit, input int k);
        @(negedge clk);
        chk({name, "_load_tx"}, 32'(tx), 32'd1);
        chk({name, "_load_rdy"}, 32'(tx_rdy), 32'd0);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            chk({name, "_bit"}, 32'(tx), 32'(lit[i]));
            repeat (k - 1) @(negedge clk);
        end
        @(negedge clk);
        chk({name, "_done"}, 32'(tx_done), 32'd1);
        chk({name, "_rdy"}, 32'(tx_rdy), 32'd1);
    endtask

    initial begin
        rst = 1'b1; write = 1'b0; data_in = '0; eight = 1'b1; pen = 1'b0;
        ohel = 1'b0; baud_k = DIV_W'(4);
        #1;
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_rdy", 32'(tx_rdy), 32'd1);
        chk("reset_done", 32'(tx_done), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);

        // 8N1 0xA5 at 4 clocks per bit, with a busy write of 0xFF mid-frame.
        send(8'hA5, 1'b1, 1'b0, 1'b0, 4);
        fork
            expect_frame("a5_8n1", 11'b111_0100_1010, 4);
            begin
                repeat (20) @(posedge clk); #1;
                data_in = 8'hFF; write = 1'b1;
                @(posedge clk); #1;
                write = 1'b0;
            end
        join
        // Back-to-back: write in the tx_done cycle, baud_k=1 runs at 2.
        data_in = 8'h5A; eight = 1'b1; pen = 1'b0; baud_k = DIV_W'(1); write = 1'b1;
        @(posedge clk); #1;
        write = 1'b0;
        expect_frame("b2b_5a", 11'b110_1011_0100, 2);
        repeat (3) @(posedge clk);

        // 7-bit even parity and 8-bit odd parity.
        send(8'h41, 1'b0, 1'b1, 1'b0, 2);
        expect_frame("41_7e", 11'b110_1000_0010, 2);
        repeat (2) @(posedge clk);
        send(8'h03, 1'b1, 1'b1, 1'b1, 3);
        expect_frame("03_8o", 11'b110_0000_0110, 3);
        repeat (2) @(posedge clk);

        // Asynchronous reset during bit 4, then a clean frame.
        send(8'hA5, 1'b1, 1'b0, 1'b0, 4);
        repeat (1 + 4 * 4 + 2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_rdy", 32'(tx_rdy), 32'd1);
        chk("midrst_done", 32'(tx_done), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        send(8'hA5, 1'b1, 1'b0, 1'b0, 4);
        expect_frame("post_rst", 11'b111_0100_1010, 4);

        // Randomized writes, configs churning every cycle.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            write   = ($urandom_range(0, 9) == 0);
            data_in = 8'($urandom_range(0, 255));
            eight   = 1'($urandom_range(0, 1));
            pen     = 1'($urandom_range(0, 1));
            ohel    = 1'($urandom_range(0, 1));
            baud_k  = DIV_W'($urandom_range(0, 5));
        end
        @(posedge clk); #1;
        write = 1'b0;
        repeat (80) @(posedge clk);
        @(negedge clk);
        #1;

        // Report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
